// File: rtl/sdram_port_arbiter_if.sv
// Bus bundle between the requester ports, the arbiter and the SDRAM controller.
// The arbiter sees it through the slave modport. The requesters and the
// controller see it through the master modport.
interface sdram_port_arbiter_if #(
  parameter int NPORTS     = 4,
  parameter int ADDR_DEPTH = 24,
  parameter int DATA_WIDTH = 16
);
  // Requester side
  logic [NPORTS-1:0]            p_req;
  logic [NPORTS-1:0]            p_we;
  logic [NPORTS*ADDR_DEPTH-1:0] p_addr;
  logic [NPORTS*DATA_WIDTH-1:0] p_wdata;
  logic [NPORTS-1:0]            p_ack;
  logic [NPORTS-1:0]            p_rvalid;
  logic [DATA_WIDTH-1:0]        p_rdata;

  // Controller side
  logic                         m_req;
  logic                         m_we;
  logic [ADDR_DEPTH-1:0]        m_addr;
  logic [DATA_WIDTH-1:0]        m_wdata;
  logic                         m_ready;
  logic                         m_rvalid;
  logic [DATA_WIDTH-1:0]        m_rdata;

  modport slave (
    input  p_req, p_we, p_addr, p_wdata, m_ready, m_rvalid, m_rdata,
    output p_ack, p_rvalid, p_rdata, m_req, m_we, m_addr, m_wdata
  );

  modport master (
    output p_req, p_we, p_addr, p_wdata, m_ready, m_rvalid, m_rdata,
    input  p_ack, p_rvalid, p_rdata, m_req, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter that shares one SDRAM controller command port among
// NPORTS requesters. A grant is held for up to HOLD_MAX back-to-back commands.
// Read data comes back in issue order and is steered to the issuing port
// through an in-order tag FIFO.
module sdram_port_arbiter #(
  parameter int NPORTS          = 4,
  parameter int ADDR_DEPTH      = 24,
  parameter int DATA_WIDTH      = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int HOLD_MAX        = 8
) (
  input  logic                clk,
  input  logic                rst,
  sdram_port_arbiter_if.slave bus,
  output logic                err_orphan
);

  localparam int OW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int HW = $clog2(HOLD_MAX + 1);

  typedef enum logic {
    ST_UNLOCKED,
    ST_LOCKED
  } state_e;

  state_e          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   last_owner_q, last_owner_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            err_orphan_q, err_orphan_d;
  logic [OW-1:0]   tag_mem_q [MAX_OUTSTANDING];

  logic            locked;
  logic            cur_req;
  logic            cur_we;
  logic            fifo_full;
  logic            fifo_empty;
  logic            handshake;
  logic            push;
  logic            pop;
  logic            pick_found;
  logic [OW-1:0]   pick_idx;
  int              rr_idx;

  // Advance a FIFO pointer, wrapping modulo MAX_OUTSTANDING.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  // Mux the owner's command to the controller and decode the handshake and read return.
  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path.
    // Otherwise a latch is inferred.
    locked     = (state_q == ST_LOCKED);
    cur_req    = bus.p_req[owner_q];
    cur_we     = bus.p_we[owner_q];
    fifo_full  = (count_q == CW'(MAX_OUTSTANDING));
    fifo_empty = (count_q == '0);

    // Reads stall while every tag slot is in use. Writes never need a tag.
    bus.m_req   = locked & cur_req & ~(~cur_we & fifo_full);
    bus.m_we    = locked & cur_we;
    bus.m_addr  = locked ? bus.p_addr[owner_q*ADDR_DEPTH +: ADDR_DEPTH] : '0;
    bus.m_wdata = locked ? bus.p_wdata[owner_q*DATA_WIDTH +: DATA_WIDTH] : '0;

    handshake   = bus.m_req & bus.m_ready;
    bus.p_ack   = handshake ? (NPORTS'(1) << owner_q) : '0;

    push        = handshake & ~cur_we;
    pop         = bus.m_rvalid & ~fifo_empty;
    bus.p_rvalid = pop ? (NPORTS'(1) << tag_mem_q[rd_ptr_q]) : '0;
    bus.p_rdata  = bus.m_rdata;
  end

  // Next grant state, hold counter, tag FIFO pointers and orphan flag.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    hold_cnt_d   = hold_cnt_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    err_orphan_d = err_orphan_q | (bus.m_rvalid & fifo_empty);

    // Round-robin search starts one past the previous owner.
    pick_found = 1'b0;
    pick_idx   = '0;
    rr_idx     = 0;
    for (int i = 1; i <= NPORTS; i++) begin
      rr_idx = int'(last_owner_q) + i;
      if (rr_idx >= NPORTS) rr_idx = rr_idx - NPORTS;
      if (!pick_found && bus.p_req[OW'(rr_idx)]) begin
        pick_found = 1'b1;
        pick_idx   = OW'(rr_idx);
      end
    end

    case (state_q)
      ST_UNLOCKED: begin
        if (pick_found) begin
          state_d    = ST_LOCKED;
          owner_d    = pick_idx;
          hold_cnt_d = '0;
        end
      end
      ST_LOCKED: begin
        if (handshake) begin
          hold_cnt_d = hold_cnt_q + HW'(1);
          if (hold_cnt_q == HW'(HOLD_MAX - 1)) begin
            state_d      = ST_UNLOCKED;
            last_owner_d = owner_q;
          end
        end else if (!cur_req) begin
          state_d      = ST_UNLOCKED;
          last_owner_d = owner_q;
        end
      end
      default: state_d = ST_UNLOCKED;
    endcase

    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  // Register the grant state machine and FIFO bookkeeping with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q      <= ST_UNLOCKED;
      owner_q      <= '0;
      last_owner_q <= OW'(NPORTS - 1);
      hold_cnt_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      hold_cnt_q   <= hold_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  // Write the issuing port's tag on every accepted read.
  always_ff @(posedge clk) begin
    // NOTE: tag storage is deliberately not reset. count_q alone says which
    // entries are valid, so stale contents are never observed.
    if (push) tag_mem_q[wr_ptr_q] <= owner_q;
  end

  assign err_orphan = err_orphan_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed self-checking bench for sdram_port_arbiter. Inputs change 1 ns after
// the rising edge and outputs are sampled on the falling edge.
module tb_sdram_port_arbiter;

  localparam int NP = 4;
  localparam int AW = 24;
  localparam int DW = 16;

  logic clk;
  logic rst;
  logic err_orphan;

  int n_checks = 0;
  int n_fail   = 0;

  sdram_port_arbiter_if #(.NPORTS(NP), .ADDR_DEPTH(AW), .DATA_WIDTH(DW)) bus ();

  sdram_port_arbiter #(
    .NPORTS(NP), .ADDR_DEPTH(AW), .DATA_WIDTH(DW),
    .MAX_OUTSTANDING(4), .HOLD_MAX(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .err_orphan (err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.p_req    = '0;
    bus.p_we     = '0;
    bus.p_addr   = '0;
    bus.p_wdata  = '0;
    bus.m_ready  = 1'b0;
    bus.m_rvalid = 1'b0;
    bus.m_rdata  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_port(input int p, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    bus.p_we[p]             = we;
    bus.p_addr[p*AW +: AW]  = a;
    bus.p_wdata[p*DW +: DW] = d;
  endtask

  task automatic check_idle_outputs(input string pfx);
    check({pfx, "_m_req"},      bus.m_req,    0);
    check({pfx, "_p_ack"},      bus.p_ack,    0);
    check({pfx, "_p_rvalid"},   bus.p_rvalid, 0);
    check({pfx, "_err_orphan"}, err_orphan,   0);
    check({pfx, "_m_we"},       bus.m_we,     0);
    check({pfx, "_m_addr"},     bus.m_addr,   0);
    check({pfx, "_m_wdata"},    bus.m_wdata,  0);
  endtask

  initial begin
    int n_acks;
    logic [NP-1:0] exp_ack;
    logic [NP-1:0] exp_rv;

    rst = 1'b1;
    idle_inputs();

    // Reset state and single write from port 0
    do_reset();
    settle();
    check_idle_outputs("rst");
    tick();
    set_port(0, 1'b1, 24'h000010, 16'hA5A5);
    bus.p_req   = 4'b0001;
    bus.m_ready = 1'b1;
    settle();
    check("t1_c0_m_req", bus.m_req, 0);
    tick();
    settle();
    check("t1_c1_m_req",   bus.m_req,   1);
    check("t1_c1_p_ack",   bus.p_ack,   4'b0001);
    check("t1_c1_m_addr",  bus.m_addr,  24'h000010);
    check("t1_c1_m_wdata", bus.m_wdata, 16'hA5A5);
    check("t1_c1_m_we",    bus.m_we,    1);
    tick();
    bus.p_req = '0;
    settle();
    check("t1_c2_p_ack", bus.p_ack, 0);
    tick();

    // All four ports stream writes: 8 acks per grant, one idle cycle between owners
    do_reset();
    for (int i = 0; i < NP; i++) set_port(i, 1'b1, AW'(24'h100 * (i + 1)), DW'(16'hB000 + i));
    bus.p_req   = 4'b1111;
    bus.m_ready = 1'b1;
    n_acks = 0;
    for (int c = 0; c < 38; c++) begin
      settle();
      exp_ack = (c % 9 == 0) ? '0 : (NP'(1) << ((c / 9) % 4));
      check($sformatf("t2_p_ack_c%0d", c), bus.p_ack, exp_ack);
      if (exp_ack != '0)
        check($sformatf("t2_m_addr_c%0d", c), bus.m_addr, 24'h100 * (((c / 9) % 4) + 1));
      if (c < 36 && bus.p_ack != '0) n_acks++;
      tick();
    end
    check("t2_total_acks", n_acks, 32);
    bus.p_req = '0;

    // Ports 1 and 2 read; controller answers with 3-cycle latency
    do_reset();
    set_port(1, 1'b0, 24'h002000, 16'h0);
    set_port(2, 1'b0, 24'h003000, 16'h0);
    bus.p_req   = 4'b0110;
    bus.m_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (c == 2) bus.p_req[1] = 1'b0;
      if (c == 5) bus.p_req[2] = 1'b0;
      bus.m_rvalid = (c == 4 || c == 7);
      bus.m_rdata  = (c == 4) ? 16'h1111 : (c == 7) ? 16'h2222 : 16'h0000;
      settle();
      exp_ack = (c == 1) ? 4'b0010 : (c == 4) ? 4'b0100 : 4'b0000;
      exp_rv  = (c == 4) ? 4'b0010 : (c == 7) ? 4'b0100 : 4'b0000;
      check($sformatf("t3_p_ack_c%0d", c),    bus.p_ack,    exp_ack);
      check($sformatf("t3_p_rvalid_c%0d", c), bus.p_rvalid, exp_rv);
      if (c == 1) check("t3_m_addr_p1", bus.m_addr, 24'h002000);
      if (c == 4) check("t3_m_addr_p2", bus.m_addr, 24'h003000);
      if (c == 4) check("t3_p_rdata_p1", bus.p_rdata, 16'h1111);
      if (c == 7) check("t3_p_rdata_p2", bus.p_rdata, 16'h2222);
      tick();
    end
    settle();
    check("t3_err_orphan", err_orphan, 0);
    tick();

    // Port 0 issues 5 reads against a 4-deep tag FIFO
    do_reset();
    set_port(0, 1'b0, 24'h000040, 16'h0);
    bus.p_req   = 4'b0001;
    bus.m_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c == 7) bus.p_req = '0;
      bus.m_rvalid = (c == 5);
      bus.m_rdata  = (c == 5) ? 16'h4444 : 16'h0000;
      settle();
      exp_ack = ((c >= 1 && c <= 4) || c == 6) ? 4'b0001 : 4'b0000;
      check($sformatf("t4_p_ack_c%0d", c), bus.p_ack, exp_ack);
      if (c == 5) begin
        check("t4_full_m_req",  bus.m_req,    0);
        check("t4_pop_rvalid",  bus.p_rvalid, 4'b0001);
        check("t4_pop_rdata",   bus.p_rdata,  16'h4444);
      end
      tick();
    end
    bus.m_rvalid = 1'b0;

    // Controller stalls for 10 cycles while port 3 requests
    do_reset();
    set_port(0, 1'b1, 24'h000AAA, 16'h0);
    set_port(1, 1'b1, 24'h000BBB, 16'h0);
    set_port(2, 1'b1, 24'h000CCC, 16'h0);
    set_port(3, 1'b1, 24'h003333, 16'h3C3C);
    bus.p_req   = 4'b1000;
    bus.m_ready = 1'b0;
    settle();
    check("t5_c0_m_req", bus.m_req, 0);
    tick();
    for (int c = 1; c <= 10; c++) begin
      settle();
      check($sformatf("t5_stall_p_ack_c%0d", c),  bus.p_ack,  0);
      check($sformatf("t5_stall_m_req_c%0d", c),  bus.m_req,  1);
      check($sformatf("t5_stall_m_addr_c%0d", c), bus.m_addr, 24'h003333);
      tick();
    end
    bus.m_ready = 1'b1;
    settle();
    check("t5_release_p_ack",   bus.p_ack,   4'b1000);
    check("t5_release_m_wdata", bus.m_wdata, 16'h3C3C);
    tick();
    bus.p_req = '0;
    settle();
    check("t5_after_p_ack", bus.p_ack, 0);
    tick();

    // Orphan read data, then reset in the middle of a burst
    do_reset();
    bus.m_rvalid = 1'b1;
    bus.m_rdata  = 16'h5555;
    settle();
    check("t6_orphan_p_rvalid", bus.p_rvalid, 0);
    check("t6_orphan_flag_c0",  err_orphan,   0);
    tick();
    bus.m_rvalid = 1'b0;
    settle();
    check("t6_orphan_flag_set", err_orphan, 1);
    tick();
    tick();
    settle();
    check("t6_orphan_flag_sticky", err_orphan, 1);
    tick();
    set_port(2, 1'b1, 24'h002222, 16'h7777);
    bus.p_req   = 4'b0100;
    bus.m_ready = 1'b1;
    settle();
    check("t6_burst_c0_p_ack", bus.p_ack, 0);
    tick();
    settle();
    check("t6_burst_c1_p_ack", bus.p_ack, 4'b0100);
    tick();
    rst = 1'b1;
    settle();
    check("t6_burst_c2_p_ack", bus.p_ack, 4'b0100);
    tick();
    rst = 1'b0;
    settle();
    check_idle_outputs("t6_post_rst");
    tick();
    settle();
    check("t6_regrant_p_ack", bus.p_ack, 4'b0100);
    tick();
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Round-robin arbiter that shares one SDRAM controller command port among NPORTS requesters, such as the hardware test pattern generator, a CPU bus bridge and a video/DMA reader. It grants one port at a time, holds the grant for up to HOLD_MAX back-to-back commands to preserve row locality, and forwards each command to the controller. It tracks outstanding reads in an in-order tag FIFO and routes each returned read word to the port that issued it. It sits between the requesters and the SDRAM controller in the top level, in the same clock domain as the controller.

## Interface
- NPORTS, 4: number of requester ports (2..8).
- ADDR_DEPTH, 24: word address width, same as the controller.
- DATA_WIDTH, 16: data width, same as the SDRAM dq.
- MAX_OUTSTANDING, 4: depth of the read tag FIFO (power of 2).
- HOLD_MAX, 8: maximum consecutive commands accepted from one port per grant (≥1).

Ports:
- clk  in  1  system clock; one clock only.
- rst  in  1  synchronous, active-high reset.
- p_req  in  NPORTS  per-port command request, held until acked.
- p_we  in  NPORTS  per-port 1 = write, 0 = read.
- p_addr  in  NPORTS*ADDR_DEPTH  per-port address, port i at slice i.
- p_wdata  in  NPORTS*DATA_WIDTH  per-port write data.
- p_ack  out  NPORTS  one-hot pulse on the cycle a port's command is accepted.
- p_rvalid  out  NPORTS  one-hot read-data strobe.
- p_rdata  out  DATA_WIDTH  read data, broadcast to all ports; qualified by p_rvalid.
- m_req  out  1  command valid to the controller.
- m_we  out  1  command type to the controller.
- m_addr  out  ADDR_DEPTH  command address to the controller.
- m_wdata  out  DATA_WIDTH  write data to the controller.
- m_ready  in  1  controller accepts the command when m_req and m_ready are both high.
- m_rvalid  in  1  controller read data valid; read data is returned in issue order.
- m_rdata  in  DATA_WIDTH  controller read data.
- err_orphan  out  1  sticky flag: m_rvalid arrived while the tag FIFO was empty.

## Operation
- The grant state machine has two states:
  - UNLOCKED: every cycle, pick the first requesting port in round-robin order, starting at last_owner+1 and wrapping at NPORTS. Register it as owner, clear hold_cnt, and go to LOCKED. With no request, stay UNLOCKED.
  - LOCKED: drive the m_* outputs from port `owner`.
- m_req = p_req[owner] & ~(read & fifo_full).
  - Writes are never blocked by a full FIFO.
  - A read is blocked while count == MAX_OUTSTANDING. The arbiter stays LOCKED and waits.
- Handshake (m_req & m_ready):
  - p_ack[owner]=1 on the same cycle; hold_cnt increments.
  - If the command is a read, push owner onto the tag FIFO.
- Return to UNLOCKED and set last_owner=owner when either:
  - a handshake occurs with hold_cnt+1 == HOLD_MAX, or
  - a cycle occurs in LOCKED with p_req[owner]==0.
- Read returns: when m_rvalid is high and the FIFO is not empty, pop the head tag h. Drive p_rvalid[h]=1 and p_rdata=m_rdata combinationally.
- When m_rvalid is high and the FIFO is empty, drop the data and set err_orphan; it clears only on rst.
- A push and a pop on the same cycle leave the count unchanged. A push is allowed only if the FIFO is not full at the start of the cycle.
- The tag FIFO count ranges 0..MAX_OUTSTANDING. Its pointers wrap modulo MAX_OUTSTANDING.

## Timing
- Reset values:
  - State UNLOCKED, last_owner=NPORTS-1 (port 0 has first priority), hold_cnt=0, FIFO empty.
  - err_orphan=0, all p_ack/p_rvalid=0, m_req=0.
  - m_we/m_addr/m_wdata=0 when not LOCKED.
- Grant latency: a request seen in cycle 0 while UNLOCKED gives m_req in cycle 1. p_ack comes in cycle 1 if m_ready=1 that cycle.
- Throughput: the owner can complete one command per cycle. Each change of owner costs exactly one idle cycle in UNLOCKED.
- While LOCKED, the m_* outputs are a combinational mux of port `owner`. p_ack and p_rvalid are combinational from m_ready and m_rvalid.
- Read data latency: zero added cycles; p_rvalid coincides with m_rvalid.
- Reset mid-operation clears the FIFO and the grant state. The controller must be reset together with the arbiter; otherwise late m_rvalid pulses set err_orphan.
- Port inputs must stay stable while p_req is high and un-acked.

## Test plan
- Single port 0 writes addr 0x000010, data 0xA5A5, m_ready=1 -> m_req in cycle 1, p_ack=0001 in cycle 1, m_addr=0x000010, m_wdata=0xA5A5.
- Ports 0–3 all request continuous writes, HOLD_MAX=8, m_ready=1 -> 8 acks to port 0, one idle cycle, then 8 to port 1, then ports 2, 3, 0 in order; 32 commands in 36 cycles.
- Ports 1 and 2 interleave reads, controller returns 0x1111 and 0x2222 in order with 3-cycle latency -> p_rvalid=0010 with 0x1111, then 0100 with 0x2222.
- Port 0 issues 5 reads, MAX_OUTSTANDING=4, no m_rvalid -> 4 acks, m_req=0 on the 5th; one m_rvalid -> 5th read acked on the next cycle.
- m_ready held 0 for 10 cycles with port 3 requesting -> p_ack stays 0, owner stays 3, m_addr stable; m_ready=1 -> single ack.
- m_rvalid pulse with empty FIFO -> no p_rvalid, err_orphan=1 until rst; rst asserted mid-burst -> all outputs return to reset values the next cycle.
